lv_efuse_load_ctrl: RTL and testbench

- Serves the efuse load request raised by the LV control FSM during WAIT_ST. Replies with a single-cycle done pulse on that FSM's i_efuse_load_done.
- Reads the efuse macro word by word through its read port, with fixed access latency.
- Writes each data word into the LV register bank and checks the trailing XOR checksum word.
- Publishes o_efuse_vld, which the register bank presents to the control FSM as i_reg_efuse_vld.

---
 rtl/lv_efuse_load_ctrl_pkg.sv | 20 ++
 rtl/lv_efuse_chk.sv | 47 ++++
 rtl/lv_efuse_load_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_lv_efuse_load_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lv_efuse_load_ctrl_pkg.sv
// lv_efuse_load_ctrl_pkg: shared LV efuse types and default geometry, so the
// load controller and the LV register bank agree on word count and widths.
package lv_efuse_load_ctrl_pkg;

  localparam int LV_EFUSE_ADDR_W      = 4;
  localparam int LV_EFUSE_DATA_W      = 8;
  localparam int LV_EFUSE_WORD_NUM    = 16;
  localparam int LV_EFUSE_RD_WAIT_CYC = 4;

  // Index of the trailing XOR checksum word; all lower words are data
  localparam int LV_EFUSE_CHK_IDX = LV_EFUSE_WORD_NUM - 1;

  typedef enum logic [1:0] {
    EFUSE_IDLE = 2'd0,
    EFUSE_RD   = 2'd1,
    EFUSE_WR   = 2'd2,
    EFUSE_DONE = 2'd3
  } efuse_state_e;

endpackage

// File: rtl/lv_efuse_chk.sv
// lv_efuse_chk: running XOR of the efuse data words plus a "some word was
// nonzero" tracker; the compare against the checksum word is combinational.
module lv_efuse_chk
  import lv_efuse_load_ctrl_pkg::*;
#(
  parameter int DATA_W = LV_EFUSE_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              acc_en_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              sum_ok_o,
  output logic              nonzero_o
);

  logic [DATA_W-1:0] acc_q, acc_d;
  logic              nz_q, nz_d;

  // Clear at the start of every pass, otherwise fold in each data word
  always_comb begin
    acc_d = acc_q;
    nz_d  = nz_q;
    if (clr_i) begin
      acc_d = '0;
      nz_d  = 1'b0;
    end else if (acc_en_i) begin
      acc_d = acc_q ^ data_i;
      nz_d  = nz_q | (|data_i);
    end
  end

  // Accumulator state, wiped by the asynchronous reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
      nz_q  <= 1'b0;
    end else begin
      acc_q <= acc_d;
      nz_q  <= nz_d;
    end
  end

  assign sum_ok_o  = (acc_q == data_i);
  assign nonzero_o = nz_q;

endmodule

// File: rtl/lv_efuse_load_ctrl.sv
// lv_efuse_load_ctrl: on a request from the LV control FSM, reads every efuse
// word, writes the data words into the LV register bank and validates the
// trailing XOR checksum word. An all-zero efuse is reported invalid.
// Build macro LV_EFUSE_RETRY_EN: a checksum mismatch on the first pass
// triggers one complete re-read; validity then reflects the second pass.
module lv_efuse_load_ctrl
  import lv_efuse_load_ctrl_pkg::*;
#(
  parameter int EFUSE_ADDR_W   = LV_EFUSE_ADDR_W,
  parameter int EFUSE_DATA_W   = LV_EFUSE_DATA_W,
  parameter int EFUSE_WORD_NUM = LV_EFUSE_WORD_NUM,
  parameter int RD_WAIT_CYC    = LV_EFUSE_RD_WAIT_CYC
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_efuse_load_req,
  output logic                    o_efuse_load_done,
  output logic                    o_efuse_busy,
  output logic                    o_efuse_rd_en,
  output logic [EFUSE_ADDR_W-1:0] o_efuse_addr,
  input  logic [EFUSE_DATA_W-1:0] i_efuse_rdata,
  output logic                    o_reg_wr_en,
  output logic [EFUSE_ADDR_W-1:0] o_reg_wr_addr,
  output logic [EFUSE_DATA_W-1:0] o_reg_wr_data,
  output logic                    o_efuse_vld
);

  localparam int WAIT_W = (RD_WAIT_CYC > 1) ? $clog2(RD_WAIT_CYC) : 1;
  localparam logic [EFUSE_ADDR_W-1:0] LAST_IDX  = EFUSE_ADDR_W'(EFUSE_WORD_NUM - 1);
  localparam logic [WAIT_W-1:0]       LAST_WAIT = WAIT_W'(RD_WAIT_CYC - 1);

  efuse_state_e            state_q, state_d;
  logic                    arm_q, arm_d;
  logic [EFUSE_ADDR_W-1:0] idx_q, idx_d;
  logic [WAIT_W-1:0]       wait_q, wait_d;
  logic [EFUSE_DATA_W-1:0] word_q, word_d;
  logic                    vld_q, vld_d;

  logic                    rd_en_q, rd_en_d;
  logic [EFUSE_ADDR_W-1:0] addr_q, addr_d;
  logic                    wr_en_q, wr_en_d;
  logic [EFUSE_ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [EFUSE_DATA_W-1:0] wr_data_q, wr_data_d;
  logic                    done_q, done_d;

  logic start, rd_last, is_last_word, last_wr, retry_now;
  logic sum_ok, nonzero;

  assign start        = (state_q == EFUSE_IDLE) && i_efuse_load_req && arm_q;
  assign rd_last      = (state_q == EFUSE_RD) && (wait_q == LAST_WAIT);
  assign is_last_word = (idx_q == LAST_IDX);
  assign last_wr      = (state_q == EFUSE_WR) && is_last_word;

`ifdef LV_EFUSE_RETRY_EN
  logic retried_q;

  // Remember that this load has already spent its single retry pass
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      retried_q <= 1'b0;
    end else if (start) begin
      retried_q <= 1'b0;
    end else if (retry_now) begin
      retried_q <= 1'b1;
    end
  end

  assign retry_now = last_wr && !sum_ok && !retried_q;
`else
  assign retry_now = 1'b0;
`endif

  lv_efuse_chk #(
    .DATA_W (EFUSE_DATA_W)
  ) u_chk (
    .clk_i     (i_clk),
    .rst_ni    (i_rst_n),
    .clr_i     (start | retry_now),
    .acc_en_i  ((state_q == EFUSE_WR) && !is_last_word),
    .data_i    (word_q),
    .sum_ok_o  (sum_ok),
    .nonzero_o (nonzero)
  );

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= EFUSE_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: one RD window then one WR cycle per word, then DONE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EFUSE_IDLE: if (start) state_d = EFUSE_RD;
      EFUSE_RD:   if (rd_last) state_d = EFUSE_WR;
      EFUSE_WR: begin
        if (!is_last_word || retry_now) begin
          state_d = EFUSE_RD;
        end else begin
          state_d = EFUSE_DONE;
        end
      end
      EFUSE_DONE: state_d = EFUSE_IDLE;
      default:    state_d = EFUSE_IDLE;
    endcase
  end

  // FSM outputs, computed one cycle ahead so every strobe leaves a flop
  always_comb begin
    rd_en_d   = (state_d == EFUSE_RD);
    addr_d    = rd_en_d ? idx_d : '0;
    wr_en_d   = rd_last && !is_last_word;
    wr_addr_d = wr_en_d ? idx_q : '0;
    wr_data_d = wr_en_d ? i_efuse_rdata : '0;
    done_d    = (state_d == EFUSE_DONE);
  end

  // Datapath next state: arm flag, word index, wait counter, capture, validity
  always_comb begin
    arm_d  = arm_q;
    idx_d  = idx_q;
    wait_d = wait_q;
    word_d = word_q;
    vld_d  = vld_q;
    if ((state_q == EFUSE_IDLE) && !i_efuse_load_req) begin
      arm_d = 1'b1;
    end
    if (start) begin
      arm_d  = 1'b0;
      vld_d  = 1'b0;
      idx_d  = '0;
      wait_d = '0;
    end
    if (state_q == EFUSE_RD) begin
      if (rd_last) begin
        wait_d = '0;
        word_d = i_efuse_rdata;
      end else begin
        wait_d = wait_q + WAIT_W'(1);
      end
    end
    if (state_q == EFUSE_WR) begin
      if (!is_last_word) begin
        idx_d = idx_q + EFUSE_ADDR_W'(1);
      end else if (retry_now) begin
        idx_d = '0;
      end else begin
        vld_d = sum_ok && nonzero;
      end
    end
  end

  // Datapath and output registers; arm is the only flop that resets to 1
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      arm_q     <= 1'b1;
      idx_q     <= '0;
      wait_q    <= '0;
      word_q    <= '0;
      vld_q     <= 1'b0;
      rd_en_q   <= 1'b0;
      addr_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      arm_q     <= arm_d;
      idx_q     <= idx_d;
      wait_q    <= wait_d;
      word_q    <= word_d;
      vld_q     <= vld_d;
      rd_en_q   <= rd_en_d;
      addr_q    <= addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
    end
  end

  assign o_efuse_busy      = (state_q == EFUSE_RD) || (state_q == EFUSE_WR);
  assign o_efuse_load_done = done_q;
  assign o_efuse_rd_en     = rd_en_q;
  assign o_efuse_addr      = addr_q;
  assign o_reg_wr_en       = wr_en_q;
  assign o_reg_wr_addr     = wr_addr_q;
  assign o_reg_wr_data     = wr_data_q;
  assign o_efuse_vld       = vld_q;

endmodule

// File: tb/tb_lv_efuse_load_ctrl.sv
// tb_lv_efuse_load_ctrl: drives efuse loads with fixed and random contents and
// compares writes, read windows, latency and validity against a word-level
// model of the load (XOR of data words vs checksum word, nonzero rule, retry).
module tb_lv_efuse_load_ctrl;

  localparam int N    = 16;
  localparam int WAIT = 4;

  logic       clk = 1'b0;
  logic       rstN;
  logic       loadReq;
  logic       loadDone;
  logic       busy;
  logic       rdEn;
  logic [3:0] efuseAddr;
  logic [7:0] efuseRdata;
  logic       regWrEn;
  logic [3:0] regWrAddr;
  logic [7:0] regWrData;
  logic       efuseVld;

  logic [7:0] mem [N];
  logic [7:0] alt15 = 8'h00;
  logic       useAlt = 1'b0;

  int         tick = 0;
  int         passCnt = 0;
  int         passBase = 0;
  int         addrUnstable = 0;
  bit         rdPrev = 1'b0;
  int         runLen = 0;
  logic [3:0] runAddr = 4'd0;
  logic [3:0] wrAddrQ [$];
  logic [7:0] wrDataQ [$];
  int         doneQ [$];
  int         runQ [$];
  logic [3:0] runAddrQ [$];

  int         errors = 0;
  int         checks = 0;

  lv_efuse_load_ctrl dut (
    .i_clk             (clk),
    .i_rst_n           (rstN),
    .i_efuse_load_req  (loadReq),
    .o_efuse_load_done (loadDone),
    .o_efuse_busy      (busy),
    .o_efuse_rd_en     (rdEn),
    .o_efuse_addr      (efuseAddr),
    .i_efuse_rdata     (efuseRdata),
    .o_reg_wr_en       (regWrEn),
    .o_reg_wr_addr     (regWrAddr),
    .o_reg_wr_data     (regWrData),
    .o_efuse_vld       (efuseVld)
  );

  always #5 clk = ~clk;

  // Efuse macro: word 15 may read differently once a second pass has begun
  assign efuseRdata = (useAlt && ((passCnt - passBase) >= 2) && (efuseAddr == 4'd15)) ? alt15 : mem[efuseAddr];

  // Passive monitor sampled on the falling edge: writes, done pulses, read windows
  always @(negedge clk) begin
    tick = tick + 1;
    if (regWrEn) begin
      wrAddrQ.push_back(regWrAddr);
      wrDataQ.push_back(regWrData);
    end
    if (loadDone) doneQ.push_back(tick);
    if (rdEn) begin
      if (!rdPrev) begin
        runLen  = 1;
        runAddr = efuseAddr;
        if (efuseAddr == 4'd0) passCnt = passCnt + 1;
      end else begin
        runLen = runLen + 1;
        if (efuseAddr != runAddr) addrUnstable = addrUnstable + 1;
      end
    end else if (rdPrev) begin
      runQ.push_back(runLen);
      runAddrQ.push_back(runAddr);
    end
    rdPrev = rdEn;
  end

  function automatic logic [31:0] outVec();
    return {11'd0, rdEn, efuseAddr, regWrEn, regWrAddr, regWrData, loadDone, busy, efuseVld};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks = checks + 1;
    if (observed !== expected) begin
      errors = errors + 1;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One complete load: start it (raising req, or releasing reset with req
  // already high), hold req 3 cycles past done, then leave req low one cycle.
  task automatic applyStimulus(input string tag, input bit fromReset);
    logic [7:0] x;
    bit         nz;
    int         passes;
    logic [7:0] w15;
    bit         expVld;
    int         expLat;
    int         wrBase, doneBase, runBase, unstBase, startTick, waited, bad;

    x = 8'h00;
    nz = 1'b0;
    for (int i = 0; i < N - 1; i++) begin
      x  = x ^ mem[i];
      nz = nz | (mem[i] != 8'h00);
    end
    passes = 1;
    w15 = mem[N-1];
`ifdef LV_EFUSE_RETRY_EN
    if (x != mem[N-1]) begin
      passes = 2;
      w15 = useAlt ? alt15 : mem[N-1];
    end
`endif
    expVld = (x == w15) && nz;
    expLat = passes * N * (WAIT + 1) + 1;

    wrBase   = wrAddrQ.size();
    doneBase = doneQ.size();
    runBase  = runQ.size();
    unstBase = addrUnstable;
    passBase = passCnt;
    startTick = tick;
    if (fromReset) rstN = 1'b1;
    else loadReq = 1'b1;

    @(negedge clk); #1;
    checkOutput({tag, ":startVld"}, 32'(efuseVld), 32'd0);
    checkOutput({tag, ":startBusy"}, 32'(busy), 32'd1);
    checkOutput({tag, ":startRd"}, {27'd0, rdEn, efuseAddr}, 32'h10);

    waited = 0;
    while ((doneQ.size() == doneBase) && (waited < 400)) begin
      @(negedge clk); #1;
      waited++;
    end
    checkOutput({tag, ":doneSeen"}, 32'(doneQ.size() > doneBase), 32'd1);
    if (doneQ.size() > doneBase) begin
      checkOutput({tag, ":latency"}, 32'(doneQ[doneBase] - startTick), 32'(expLat));
    end
    checkOutput({tag, ":vld"}, 32'(efuseVld), 32'(expVld));

    repeat (3) begin
      @(negedge clk); #1;
    end
    loadReq = 1'b0;
    @(negedge clk); #1;

    checkOutput({tag, ":donePulses"}, 32'(doneQ.size() - doneBase), 32'd1);
    checkOutput({tag, ":idleBusy"}, {30'd0, busy, rdEn}, 32'd0);
    checkOutput({tag, ":vldHeld"}, 32'(efuseVld), 32'(expVld));

    checkOutput({tag, ":wrCount"}, 32'(wrAddrQ.size() - wrBase), 32'(passes * (N - 1)));
    for (int k = 0; k < passes * (N - 1); k++) begin
      if (wrBase + k < wrAddrQ.size()) begin
        checkOutput($sformatf("%s:wrAddr%0d", tag, k), 32'(wrAddrQ[wrBase + k]), 32'(k % (N - 1)));
        checkOutput($sformatf("%s:wrData%0d", tag, k), 32'(wrDataQ[wrBase + k]), 32'(mem[k % (N - 1)]));
      end
    end

    bad = 0;
    for (int k = runBase; k < runQ.size(); k++) begin
      if (runQ[k] != WAIT) bad++;
      if (int'(runAddrQ[k]) != ((k - runBase) % N)) bad++;
    end
    checkOutput({tag, ":rdRuns"}, 32'(runQ.size() - runBase), 32'(passes * N));
    checkOutput({tag, ":rdRunShape"}, 32'(bad), 32'd0);
    checkOutput({tag, ":addrStable"}, 32'(addrUnstable - unstBase), 32'd0);
  endtask

  initial begin
    logic [7:0] x;
    int         startTick;

    rstN = 1'b0;
    loadReq = 1'b0;
    for (int i = 0; i < N; i++) mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("resetOutputs", outVec(), 32'd0);
    rstN = 1'b1;
    @(negedge clk); #1;
    checkOutput("idleOutputs", outVec(), 32'd0);

    // Ascending data words with the matching checksum word
    x = 8'h00;
    for (int i = 0; i < N - 1; i++) begin
      mem[i] = 8'(i + 1);
      x = x ^ mem[i];
    end
    mem[N-1] = x;
    applyStimulus("valid", 1'b0);
    // Back-to-back load one cycle after req drops: vld must clear at its start
    applyStimulus("reload", 1'b0);

    mem[N-1] = x ^ 8'h01;
    applyStimulus("badSum", 1'b0);

    mem[N-1] = x ^ 8'h01;
    alt15 = x;
    useAlt = 1'b1;
    applyStimulus("altSecondPass", 1'b0);
    useAlt = 1'b0;

    for (int i = 0; i < N; i++) mem[i] = 8'h00;
    applyStimulus("allZero", 1'b0);

    // Abort during the read window of word 5, then restart out of reset
    for (int i = 0; i < N; i++) mem[i] = 8'(8'h30 + i);
    startTick = tick;
    loadReq = 1'b1;
    while (tick < startTick + 27) begin
      @(negedge clk); #1;
    end
    checkOutput("midLoadRd", {27'd0, rdEn, efuseAddr}, 32'h15);
    rstN = 1'b0;
    #1;
    checkOutput("abortOutputs", outVec(), 32'd0);
    repeat (2) @(negedge clk);
    #1;
    applyStimulus("afterReset", 1'b1);

    for (int r = 0; r < 6; r++) begin
      x = 8'h00;
      for (int i = 0; i < N - 1; i++) begin
        mem[i] = (r == 5 && i != 7) ? 8'h00 : 8'($urandom_range(0, 255));
        x = x ^ mem[i];
      end
      case (r % 3)
        0: mem[N-1] = x;
        1: mem[N-1] = x ^ 8'($urandom_range(1, 255));
        default: mem[N-1] = 8'($urandom_range(0, 255));
      endcase
      useAlt = ($urandom_range(0, 1) == 1);
      alt15 = x;
      applyStimulus($sformatf("random%0d", r), 1'b0);
    end
    useAlt = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
